// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types for the PRBS error injector
package prbs_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        SINGLE   = 2'd1,
        PERIODIC = 2'd2,
        BURST    = 2'd3
    } inj_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } inj_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            // a clear that coincides with an increment still counts that event
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prbs_err_inject.sv
// rtl/prbs_err_inject.sv - registered PRBS passthrough with single/periodic/burst bit-flip injection
module prbs_err_inject
    import prbs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         prbs_in,
    output logic [WIDTH-1:0]         prbs_out,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         period,
    input  logic [CNT_W-1:0]         burst_len,
    input  logic [$clog2(WIDTH)-1:0] bit_sel,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     cnt_clr,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         inj_cnt
);

    localparam int SEL_W = $clog2(WIDTH);

    inj_state_t       state, state_n;
    inj_mode_t        mode_l;
    logic [CNT_W-1:0] lim_l;
    logic [SEL_W-1:0] sel_l;
    logic [CNT_W-1:0] wcnt, wcnt_n;
    logic             inject;
    logic             load;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] lim_src;
    logic [CNT_W-1:0] lim_n;
    logic [SEL_W-1:0] sel_n;

    // One latched limit serves both modes: period-1 or burst_len-1, with 0 treated as 1
    assign lim_src = (inj_mode_t'(mode) == BURST) ? burst_len : period;
    assign lim_n   = (lim_src == '0) ? '0 : lim_src - CNT_W'(1);
    assign sel_n   = (int'(bit_sel) > WIDTH - 1) ? SEL_W'(WIDTH - 1) : bit_sel;

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        inject  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (arm && (inj_mode_t'(mode) != OFF)) begin
                    state_n = ACTIVE;
                    load    = 1'b1;
                    wcnt_n  = '0;
                end
            end
            ACTIVE: begin
                // stop wins over an injection on the same word
                if (stop) begin
                    state_n = IDLE;
                end else if (en) begin
                    case (mode_l)
                        SINGLE: begin
                            inject  = 1'b1;
                            state_n = DONE;
                        end
                        PERIODIC: begin
                            if (wcnt == lim_l) begin
                                inject = 1'b1;
                                wcnt_n = '0;
                            end else begin
                                wcnt_n = wcnt + CNT_W'(1);
                            end
                        end
                        BURST: begin
                            inject = 1'b1;
                            if (wcnt == lim_l) begin
                                state_n = DONE;
                            end else begin
                                wcnt_n = wcnt + CNT_W'(1);
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wcnt   <= '0;
            mode_l <= OFF;
            lim_l  <= '0;
            sel_l  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (load) begin
                mode_l <= inj_mode_t'(mode);
                lim_l  <= lim_n;
                sel_l  <= sel_n;
            end
        end
    end

    assign mask = inject ? (WIDTH'(1) << sel_l) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prbs_out <= '0;
        end else if (en) begin
            prbs_out <= prbs_in ^ mask;
        end
    end

    assign busy = (state == ACTIVE);
    assign done = (state == DONE);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_inj_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (inject),
        .cnt  (inj_cnt)
    );

endmodule

// File: tb/tb_prbs_err_inject.sv
// tb/tb_prbs_err_inject.sv - directed table-driven bench for prbs_err_inject
module tb_prbs_err_inject;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  prbs_in = '0;
    logic [7:0]  prbs_out;
    logic [1:0]  mode = '0;
    logic [15:0] period = '0;
    logic [15:0] burst_len = '0;
    logic [2:0]  bit_sel = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        busy, done;
    logic [15:0] inj_cnt;

    logic [1:0]  mode4 = '0;
    logic [3:0]  period4 = '0;
    logic [3:0]  burst_len4 = '0;
    logic        arm4 = 1'b0;
    logic        cnt_clr4 = 1'b0;
    logic [7:0]  prbs_out4;
    logic        busy4, done4;
    logic [3:0]  inj_cnt4;

    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    prbs_err_inject #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .prbs_in(prbs_in), .prbs_out(prbs_out),
        .mode(mode), .period(period), .burst_len(burst_len), .bit_sel(bit_sel),
        .arm(arm), .stop(stop), .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .inj_cnt(inj_cnt)
    );

    prbs_err_inject #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .prbs_in(prbs_in), .prbs_out(prbs_out4),
        .mode(mode4), .period(period4), .burst_len(burst_len4), .bit_sel(bit_sel),
        .arm(arm4), .stop(stop), .cnt_clr(cnt_clr4), .busy(busy4), .done(done4),
        .inj_cnt(inj_cnt4)
    );

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic       arm;
        logic       stop;
        logic [1:0] mode;
        logic [2:0] sel;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vec[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] d);
        en = e;
        prbs_in = d;
        @(posedge clk);
        #1;
        arm = 1'b0;
        stop = 1'b0;
        cnt_clr = 1'b0;
        arm4 = 1'b0;
        cnt_clr4 = 1'b0;
        if (done) done_seen++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        // en din arm stop mode sel | q busy done cnt
        vec[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 3'd0, 8'h11, 1'b0, 1'b0, 16'd0};
        vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 3'd0, 8'h22, 1'b0, 1'b0, 16'd0};
        vec[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 2'd1, 3'd3, 8'hA5, 1'b1, 1'b0, 16'd0};
        vec[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 2'd1, 3'd3, 8'h34, 1'b0, 1'b1, 16'd1};
        vec[4]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 2'd1, 3'd3, 8'h0F, 1'b0, 1'b0, 16'd1};
        vec[5]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 2'd1, 3'd3, 8'h0F, 1'b0, 1'b0, 16'd1};
        vec[6]  = '{1'b1, 8'h80, 1'b1, 1'b0, 2'd1, 3'd7, 8'h80, 1'b1, 1'b0, 16'd1};
        vec[7]  = '{1'b0, 8'h55, 1'b0, 1'b0, 2'd1, 3'd7, 8'h80, 1'b1, 1'b0, 16'd1};
        vec[8]  = '{1'b0, 8'h66, 1'b0, 1'b0, 2'd1, 3'd7, 8'h80, 1'b1, 1'b0, 16'd1};
        vec[9]  = '{1'b1, 8'h81, 1'b0, 1'b0, 2'd1, 3'd7, 8'h01, 1'b0, 1'b1, 16'd2};
        vec[10] = '{1'b1, 8'h42, 1'b0, 1'b1, 2'd1, 3'd7, 8'h42, 1'b0, 1'b0, 16'd2};
        vec[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 2'd1, 3'd0, 8'h00, 1'b1, 1'b0, 16'd2};
        vec[12] = '{1'b1, 8'hF0, 1'b0, 1'b1, 2'd1, 3'd0, 8'hF0, 1'b0, 1'b0, 16'd2};

        #12;
        chk("reset prbs_out", prbs_out, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset inj_cnt", inj_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            arm = vec[i].arm;
            stop = vec[i].stop;
            mode = vec[i].mode;
            bit_sel = vec[i].sel;
            step(vec[i].en, vec[i].din);
            chk($sformatf("vec%0d prbs_out", i), prbs_out, vec[i].q);
            chk($sformatf("vec%0d busy", i), busy, vec[i].busy);
            chk($sformatf("vec%0d done", i), done, vec[i].done);
            chk($sformatf("vec%0d inj_cnt", i), inj_cnt, vec[i].cnt);
        end

        // PERIODIC, period 10, bit 2
        done_seen = 0;
        mode = 2'd2;
        period = 16'd10;
        bit_sel = 3'd2;
        arm = 1'b1;
        step(1'b1, 8'h99);
        chk("per arm busy", busy, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            d = 8'($urandom);
            step(1'b1, d);
            chk($sformatf("per word%0d", k), prbs_out, d ^ ((k % 10 == 0) ? 8'h04 : 8'h00));
        end
        chk("per busy before stop", busy, 1'b1);
        stop = 1'b1;
        step(1'b1, 8'h77);
        chk("per stop word clean", prbs_out, 8'h77);
        chk("per busy after stop", busy, 1'b0);
        chk("per inj_cnt", inj_cnt, 16'd12);
        chk("per no done", done_seen, 0);

        // BURST, length 4, bit 5, en gap and ignored arm mid-burst
        mode = 2'd3;
        burst_len = 16'd4;
        bit_sel = 3'd5;
        arm = 1'b1;
        step(1'b1, 8'h01);
        chk("bst arm out", prbs_out, 8'h01);
        step(1'b1, 8'h02);
        chk("bst w1", prbs_out, 8'h22);
        step(1'b1, 8'h03);
        chk("bst w2", prbs_out, 8'h23);
        for (int g = 0; g < 5; g++) begin
            if (g == 2) begin
                arm = 1'b1;
                mode = 2'd1;
                bit_sel = 3'd0;
            end
            step(1'b0, 8'hEE);
            chk($sformatf("bst gap%0d out", g), prbs_out, 8'h23);
            chk($sformatf("bst gap%0d busy", g), busy, 1'b1);
        end
        step(1'b1, 8'h04);
        chk("bst w3", prbs_out, 8'h24);
        chk("bst w3 done", done, 1'b0);
        step(1'b1, 8'h05);
        chk("bst w4", prbs_out, 8'h25);
        chk("bst w4 done", done, 1'b1);
        chk("bst w4 busy", busy, 1'b0);
        step(1'b1, 8'h06);
        chk("bst after out", prbs_out, 8'h06);
        chk("bst after done", done, 1'b0);
        chk("bst inj_cnt", inj_cnt, 16'd16);

        // reset mid-BURST, no clock edge needed
        mode = 2'd3;
        burst_len = 16'd10;
        bit_sel = 3'd0;
        arm = 1'b1;
        step(1'b1, 8'h10);
        step(1'b1, 8'h20);
        chk("rst pre out", prbs_out, 8'h21);
        #2;
        reset = 1'b0;
        #1;
        chk("rst async out", prbs_out, 8'h00);
        chk("rst async busy", busy, 1'b0);
        chk("rst async cnt", inj_cnt, 16'd0);
        step(1'b1, 8'h30);
        reset = 1'b1;
        step(1'b1, 8'h5A);
        chk("rst pass1", prbs_out, 8'h5A);
        chk("rst pass busy", busy, 1'b0);
        step(1'b1, 8'hC3);
        chk("rst pass2", prbs_out, 8'hC3);

        // CNT_W=4, PERIODIC with period 0: every word, saturating count
        mode4 = 2'd2;
        period4 = 4'd0;
        bit_sel = 3'd1;
        arm4 = 1'b1;
        step(1'b1, 8'h00);
        chk("c4 busy", busy4, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            d = 8'($urandom);
            step(1'b1, d);
            chk($sformatf("c4 word%0d", k), prbs_out4, d ^ 8'h02);
        end
        chk("c4 saturated", inj_cnt4, 4'd15);
        cnt_clr4 = 1'b1;
        step(1'b1, 8'hA0);
        chk("c4 clr+inj out", prbs_out4, 8'hA2);
        chk("c4 clr+inj cnt", inj_cnt4, 4'd1);
        stop = 1'b1;
        step(1'b1, 8'hB0);
        chk("c4 stop out", prbs_out4, 8'hB0);
        chk("c4 stop busy", busy4, 1'b0);
        chk("c4 stop cnt", inj_cnt4, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
